// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   STALL_* masks   per-request stall vectors; bit i stops stage i (0=PC ... 5=WB)
//   STOP/NO_STOP    meaning of a single stall bit
//   seq_state_e     EX multi-cycle sequencer states
//   stall_req_t     bundled per-stage stall requests
//   stall_merge()   priority merge of the requests into one stall vector
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Each mask stops the requesting stage and everything upstream of it.
  // WB (bit 5) is never stopped, so a MEM stall drains a bubble into WB.
  localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
  localparam logic [5:0] STALL_IF   = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP, STOP};
  localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP, STOP, STOP, STOP, STOP};

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_MULTI = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic req_mem;
    logic req_ex;   // generic EX request OR'ed with the multi-cycle hold
    logic req_id;
    logic req_if;
  } stall_req_t;

  // The furthest-downstream requester wins: its mask is a superset of
  // every upstream mask.
  function automatic logic [5:0] stall_merge(input stall_req_t r);
    logic [5:0] v;
    v = STALL_NONE;
    if (r.req_mem)     v = STALL_MEM;
    else if (r.req_ex) v = STALL_EX;
    else if (r.req_id) v = STALL_ID;
    else if (r.req_if) v = STALL_IF;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_seq.sv
// EX multi-cycle sequencer: holds EX for N cycles after the start cycle, then pulses done.
// Latency: o_multi_stall is asserted combinationally in the start cycle; done appears N+1 cycles later.
// Backpressure: a MEM stall keeps the sequencer in DONE (done held) but never slows the count-down.
//
// Ports:
//   clk, rst         pipeline clock, asynchronous active-high reset
//   i_start          one-cycle start pulse (ignored unless idle or when i_flush is high)
//   i_cycles         busy cycles for the op; 0 is treated as 1
//   i_flush          kills the op; no done pulse follows
//   i_mem_stall      MEM stage stalled; extends the DONE state
//   o_multi_stall    EX-level stall request from the sequencer
//   o_busy           sequencer in MULTI
//   o_done           EX result valid this cycle
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cycles,
  input  logic             i_flush,
  input  logic             i_mem_stall,
  output logic             o_multi_stall,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cycles_eff;

  // A zero-length op still needs one MULTI cycle so the done handshake exists.
  assign w_cycles_eff = (i_cycles == '0) ? CNT_ONE : i_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    o_multi_stall = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (i_start && !i_flush) begin
          // The issuing cycle already holds EX so the op's operands stay put.
          o_multi_stall = 1'b1;
          w_state_nxt   = SEQ_MULTI;
          w_cnt_nxt     = w_cycles_eff;
        end
      end
      SEQ_MULTI: begin
        o_multi_stall = 1'b1;
        o_busy        = 1'b1;
        // Count down unconditionally: the functional unit keeps working
        // even while MEM holds the pipeline.
        w_cnt_nxt     = r_cnt - CNT_ONE;
        if (i_flush) begin
          w_state_nxt = SEQ_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        o_done = !i_flush;
        // Keep the result presented until EX can actually advance.
        if (i_flush || !i_mem_stall) begin
          w_state_nxt = SEQ_IDLE;
        end
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the PC/IF/ID/EX/MEM/WB pipeline.
// Latency: stall and flush are combinational from the requests (same cycle).
// Backpressure: a downstream stall freezes all upstream stages; WB never stalls.
//
// Optional feature macro: PIPE_CTRL_PERF_EN builds saturating performance
// counters; without it the perf outputs are tied to zero and no flops exist.
//
// Ports:
//   clk, rst                          pipeline clock, asynchronous active-high reset
//   stallreq_if/id/ex/mem             per-stage stall requests
//   flush_req                         exception/redirect; overrides every stall
//   ex_multi_start, ex_multi_cycles   multi-cycle EX op issue and its length
//   stall[5:0]                        per-stage stop, bit 0 = PC ... bit 5 = WB
//   flush                             flush all pipeline registers this cycle
//   ex_multi_busy, ex_multi_done      sequencer status
//   perf_stall_cycles                 cycles with stall[0]=1
//   perf_flush_count                  flush cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              flush_req,
  input  logic              ex_multi_start,
  input  logic [CNT_W-1:0]  ex_multi_cycles,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              ex_multi_busy,
  output logic              ex_multi_done,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flush_count
);

  logic       w_multi_stall;
  stall_req_t w_req;
  logic [5:0] w_stall_merged;

  pipe_ctrl_seq #(
    .CNT_W (CNT_W)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .i_start       (ex_multi_start),
    .i_cycles      (ex_multi_cycles),
    .i_flush       (flush_req),
    .i_mem_stall   (stallreq_mem),
    .o_multi_stall (w_multi_stall),
    .o_busy        (ex_multi_busy),
    .o_done        (ex_multi_done)
  );

  always_comb begin
    w_req         = '0;
    w_req.req_mem = stallreq_mem;
    w_req.req_ex  = stallreq_ex | w_multi_stall;
    w_req.req_id  = stallreq_id;
    w_req.req_if  = stallreq_if;
  end

  assign w_stall_merged = stall_merge(w_req);

  // A flush empties the pipe, so holding any stage would only keep killed
  // work around; reset likewise forces everything quiet.
  assign stall = (rst || flush_req) ? STALL_NONE : w_stall_merged;
  assign flush = flush_req && !rst;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (stall[0] && (r_perf_stall != PERF_MAX)) begin
        r_perf_stall <= r_perf_stall + PERF_ONE;
      end
      if (flush && (r_perf_flush != PERF_MAX)) begin
        r_perf_flush <= r_perf_flush + PERF_ONE;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs queued by the driver and checked by a monitor.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int CNT_W  = 6;
  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stallreq_if = 1'b0;
  logic              stallreq_id = 1'b0;
  logic              stallreq_ex = 1'b0;
  logic              stallreq_mem = 1'b0;
  logic              flush_req = 1'b0;
  logic              ex_multi_start = 1'b0;
  logic [CNT_W-1:0]  ex_multi_cycles = '0;
  logic [5:0]        stall;
  logic              flush;
  logic              ex_multi_busy;
  logic              ex_multi_done;
  logic [PERF_W-1:0] perf_stall_cycles;
  logic [PERF_W-1:0] perf_flush_count;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_if       (stallreq_if),
    .stallreq_id       (stallreq_id),
    .stallreq_ex       (stallreq_ex),
    .stallreq_mem      (stallreq_mem),
    .flush_req         (flush_req),
    .ex_multi_start    (ex_multi_start),
    .ex_multi_cycles   (ex_multi_cycles),
    .stall             (stall),
    .flush             (flush),
    .ex_multi_busy     (ex_multi_busy),
    .ex_multi_done     (ex_multi_done),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );

  typedef struct packed {
    logic [5:0]        stall;
    logic              flush;
    logic              busy;
    logic              done;
    logic [PERF_W-1:0] pst;
    logic [PERF_W-1:0] pfl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: an op is a time window. It holds EX from its issue
  // cycle through issue+N, then presents done until MEM lets it go.
  int     cyc = 0;
  bit     op_active = 0;
  int     op_start = 0;
  int     op_n = 0;
  longint m_pst = 0;
  longint m_pfl = 0;

  task automatic step(input bit r, input bit s_if, input bit s_id, input bit s_ex,
                      input bit s_mem, input bit fl, input bit st, input int cy);
    exp_t e;
    bit   ex_hold;
    bit   in_done;
    @(posedge clk);
    #1;
    rst             = r;
    stallreq_if     = s_if;
    stallreq_id     = s_id;
    stallreq_ex     = s_ex;
    stallreq_mem    = s_mem;
    flush_req       = fl;
    ex_multi_start  = st;
    ex_multi_cycles = 6'(cy);
    cyc++;
    e = '0;
    e.pst = PERF_W'(m_pst);
    e.pfl = PERF_W'(m_pfl);
    if (r) begin
      op_active = 0;
      m_pst = 0;
      m_pfl = 0;
      e.pst = '0;
      e.pfl = '0;
    end else begin
      if (!op_active && st && !fl) begin
        op_active = 1;
        op_start  = cyc;
        op_n      = ((cy % 64) == 0) ? 1 : (cy % 64);
      end
      ex_hold = op_active && (cyc <= op_start + op_n);
      in_done = op_active && (cyc > op_start + op_n);
      e.busy  = op_active && (cyc > op_start) && (cyc <= op_start + op_n);
      e.done  = in_done && !fl;
      e.flush = fl;
      if (fl)                  e.stall = 6'b000000;
      else if (s_mem)          e.stall = 6'b011111;
      else if (s_ex || ex_hold) e.stall = 6'b001111;
      else if (s_id)           e.stall = 6'b000111;
      else if (s_if)           e.stall = 6'b000011;
      else                     e.stall = 6'b000000;
      if (e.stall[0]) m_pst++;
      if (fl) m_pfl++;
      if (fl || (in_done && !s_mem)) op_active = 0;
    end
`ifndef PIPE_CTRL_PERF_EN
    e.pst = '0;
    e.pfl = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("stall", longint'(stall), longint'(mon_e.stall));
      chk("flush", longint'(flush), longint'(mon_e.flush));
      chk("busy", longint'(ex_multi_busy), longint'(mon_e.busy));
      chk("done", longint'(ex_multi_done), longint'(mon_e.done));
      chk("perf_stall", longint'(perf_stall_cycles), longint'(mon_e.pst));
      chk("perf_flush", longint'(perf_flush_count), longint'(mon_e.pfl));
    end
  end

  initial begin
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0, 1, 3);
    idle(1);
    // priority merge
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0, 0);
    idle(1);
    // 3-cycle op, then a zero-length op
    step(0, 0, 0, 0, 0, 0, 1, 3);
    idle(6);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // 5-cycle op flushed on its third MULTI cycle; restart during MULTI ignored
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0, 0, 1, 9);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(7);
    // start coincident with flush is ignored
    step(0, 0, 0, 0, 0, 1, 1, 4);
    idle(3);
    // 2-cycle op with MEM held for 3 cycles from DONE
    step(0, 0, 0, 0, 0, 0, 1, 2);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);
    // flush while in DONE
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);
    // counters: 10 stalled cycles and 2 flushes after a clean reset
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // reset in the middle of a long op
    step(0, 0, 0, 0, 0, 0, 1, 10);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(12);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int cyv;
      cyv = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0), cyv);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
